// File: rtl/seq_divider_32by16.sv
// seq_divider_32by16: sequential restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start, Z (dividend), B (divisor) in;
//        busy, done (1-cycle pulse), Q (quotient), R (remainder) out;
//        dbz (divide-by-zero flag) only when DIV_ZERO_FLAG_EN is defined.
module seq_divider_32by16 #(
    parameter int WN = 32,
    parameter int WD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WN-1:0] Z,
    input  logic [WD-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [WN-1:0] Q,
    output logic [WD-1:0] R
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic          dbz
`endif
);

    localparam int CW = $clog2(WN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [WN-1:0] dvd_q, dvd_d;
    logic [WD-1:0] dsr_q, dsr_d;
    logic [WD-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [WN-1:0] q_q, q_d;
    logic [WD-1:0] r_q, r_d;
    logic [WD:0]   trial;
    logic          qbit;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        trial   = '0;
        qbit    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = Z;
                    dsr_d   = B;
                    rem_d   = '0;
                    cnt_d   = CW'(WN);
                    busy_d  = 1'b1;
                    dz_d    = (B == '0);
                    state_d = (B == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                // Remainder stays below the divisor, so the widened shift
                // never loses its top bit.
                trial = {rem_q, dvd_q[WN-1]};
                if (trial >= {1'b0, dsr_q}) begin
                    trial = trial - {1'b0, dsr_q};
                    qbit  = 1'b1;
                end
                rem_d = trial[WD-1:0];
                // Quotient bits fill the dividend register from the bottom.
                dvd_d = {dvd_q[WN-2:0], qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                q_d     = dz_q ? '1 : dvd_q;
                r_d     = dz_q ? dvd_q[WD-1:0] : rem_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;

`ifdef DIV_ZERO_FLAG_EN
    logic dbz_q, dbz_d;

    // Flag follows each result and holds until the next one.
    always_comb begin
        dbz_d = dbz_q;
        if (state_q == S_FIN) begin
            dbz_d = dz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign dbz = dbz_q;
`endif

endmodule
